// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the burst SPI-to-register bridge.
package spi_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_WR   = 2'd2,
      ST_RD   = 2'd3
   } state_t;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   // Header is one rw bit followed by the address.
   function automatic int hdr_width(input int addr_w);
      return addr_w + 1;
   endfunction

   // rw travels first, so it ends up as the header MSB.
   function automatic int rw_pos(input int addr_w);
      return addr_w;
   endfunction

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Read-data shifter: parallel load from the register file, MSB-first shift,
// and the negedge miso flop that only a real reset clears.
module spi_tx_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              shift_en,
   input  logic              tx_active,
   output logic              miso
);

   logic              clr_n;
   logic [DATA_W-1:0] tx_shift;

   assign clr_n = rst_n & ~cs_n;

   // Load a new word on the strobe edge, otherwise shift the next bit to the MSB.
   always_ff @(posedge sclk or negedge clr_n) begin
      if (!clr_n) begin
         tx_shift <= '0;
      end else if (load) begin
         tx_shift <= load_data;
      end else if (shift_en) begin
         tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
   end

   // Present the MSB half a cycle ahead of the master's sampling edge.
   always_ff @(negedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         miso <= 1'b0;
      end else begin
         miso <= (!cs_n && tx_active) ? tx_shift[DATA_W-1] : 1'b0;
      end
   end

endmodule

// File: rtl/spi_bridge_burst.sv
// SPI mode-0 slave bridging addressed burst frames onto the register bus.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | frame selected, no bit sampled yet (first header bit next)
// ST_HDR  | shifting in the rw bit and address
// ST_WR   | receiving write words, strobing wr_en on each last bit
// ST_RD   | shifting read words out, prefetching on each last bit
module spi_bridge_burst
   import spi_bridge_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 7,
   parameter int AUTO_INC = 1
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data
);

   localparam int HDR_W  = hdr_width(ADDR_W);
   localparam int RW_POS = rw_pos(ADDR_W);
   localparam int SH_W   = max_w(DATA_W, HDR_W);
   // The newest bit comes straight from mosi, so one bit less is stored.
   localparam int SR_W   = SH_W - 1;
   localparam int CNT_W  = $clog2(SH_W);
   localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   logic              clr_n;
   state_t            state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic [SR_W-1:0]   rx_shift, rx_shift_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt, addr_inc;
   logic [HDR_W-1:0]  hdr_word;
   logic [DATA_W-1:0] data_word;
   logic              hdr_last, word_last, in_data;

   // Deselect behaves like reset for everything except the miso flop.
   assign clr_n = rst_n & ~cs_n;

   assign hdr_word  = {rx_shift[HDR_W-2:0], mosi};
   assign data_word = {rx_shift[DATA_W-2:0], mosi};
   assign addr_inc  = (AUTO_INC != 0) ? addr + 1'b1 : addr;
   assign in_data   = (state == ST_WR) || (state == ST_RD);
   assign hdr_last  = (state == ST_HDR) && (bit_cnt == HDR_LAST);
   assign word_last = in_data && (bit_cnt == DATA_LAST);

   // State, counters and receive shifter.
   always_ff @(posedge sclk or negedge clr_n) begin
      if (!clr_n) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         rx_shift <= '0;
         addr     <= '0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         rx_shift <= rx_shift_nxt;
         addr     <= addr_nxt;
      end
   end

   // Next-state decode and the combinational bus strobes.
   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      addr_nxt     = addr;
      rx_shift_nxt = SR_W'({rx_shift, mosi});
      wr_en        = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      rd_en        = 1'b0;
      rd_addr      = '0;

      case (state)
         ST_IDLE: begin
            state_nxt   = ST_HDR;
            bit_cnt_nxt = CNT_W'(1);
         end
         ST_HDR: begin
            if (hdr_last) begin
               addr_nxt    = hdr_word[ADDR_W-1:0];
               bit_cnt_nxt = '0;
               state_nxt   = (hdr_word[RW_POS] == RW_WRITE) ? ST_WR : ST_RD;
            end else begin
               bit_cnt_nxt = bit_cnt + 1'b1;
            end
         end
         ST_WR, ST_RD: begin
            if (word_last) begin
               bit_cnt_nxt = '0;
               addr_nxt    = addr_inc;
            end else begin
               bit_cnt_nxt = bit_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (!cs_n && word_last && (state == ST_WR)) begin
         wr_en   = 1'b1;
         wr_addr = addr;
         wr_data = data_word;
      end

      // The header strobe fetches the addressed word; data strobes prefetch the next.
      if (!cs_n && hdr_last && (hdr_word[RW_POS] == RW_READ)) begin
         rd_en   = 1'b1;
         rd_addr = hdr_word[ADDR_W-1:0];
      end else if (!cs_n && word_last && (state == ST_RD)) begin
         rd_en   = 1'b1;
         rd_addr = addr_inc;
      end
   end

   spi_tx_shifter #(
      .DATA_W (DATA_W)
   ) u_tx (
      .sclk      (sclk),
      .rst_n     (rst_n),
      .cs_n      (cs_n),
      .load      (rd_en),
      .load_data (rd_data),
      .shift_en  (state == ST_RD),
      .tx_active (state == ST_RD),
      .miso      (miso)
   );

endmodule

// File: tb/tb_spi_bridge_burst.sv
// Bench for spi_bridge_burst: one auto-increment and one fixed-address instance
// share the SPI pins; a frame-level model predicts each bit period's outputs.
module tb_spi_bridge_burst;

   logic       sclk = 1'b0;
   logic       rst_n, cs_n, mosi;
   logic       miso_i, wr_en_i, rd_en_i;
   logic [6:0] wr_addr_i, rd_addr_i;
   logic [7:0] wr_data_i, rd_data_i;
   logic       miso_n, wr_en_n, rd_en_n;
   logic [6:0] wr_addr_n, rd_addr_n;
   logic [7:0] wr_data_n, rd_data_n;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  m_hdr;
   logic [7:0]  m_words [3];
   int          cur_k;
   bit          valid    = 1'b0;
   int          idle_cnt = 0;
   logic [15:0] wlog_i[$], wlog_n[$];
   logic [6:0]  rlog_i[$];
   logic [15:0] mis_i;

   always #5 sclk = ~sclk;

   // Register file contents seen by the bridge: value = address + 0x40.
   assign rd_data_i = {1'b0, rd_addr_i} + 8'h40;
   assign rd_data_n = {1'b0, rd_addr_n} + 8'h40;

   spi_bridge_burst #(.DATA_W(8), .ADDR_W(7), .AUTO_INC(1)) dut_i (
      .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso_i),
      .wr_en(wr_en_i), .wr_addr(wr_addr_i), .wr_data(wr_data_i),
      .rd_en(rd_en_i), .rd_addr(rd_addr_i), .rd_data(rd_data_i));

   spi_bridge_burst #(.DATA_W(8), .ADDR_W(7), .AUTO_INC(0)) dut_n (
      .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso_n),
      .wr_en(wr_en_n), .wr_addr(wr_addr_n), .wr_data(wr_data_n),
      .rd_en(rd_en_n), .rd_addr(rd_addr_n), .rd_data(rd_data_n));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] reg_val(input logic [6:0] a);
      return {1'b0, a} + 8'h40;
   endfunction

   // Expected outputs during bit period k of the current frame.
   function automatic void model(input int k, input bit inc,
                                 output bit e_wr, output logic [6:0] e_wa, output logic [7:0] e_wd,
                                 output bit e_rd, output logic [6:0] e_ra, output bit e_mo);
      logic [6:0] a0, aj;
      logic [7:0] v;
      int j, b;
      a0 = m_hdr[6:0];
      e_wr = 0; e_wa = '0; e_wd = '0; e_rd = 0; e_ra = '0; e_mo = 0;
      if (k == 7 && m_hdr[7] == 1'b0) begin
         e_rd = 1; e_ra = a0;
      end
      if (k >= 8) begin
         j  = (k - 8) / 8;
         b  = (k - 8) % 8;
         aj = inc ? 7'(int'(a0) + j) : a0;
         if (m_hdr[7]) begin
            if (b == 7) begin
               e_wr = 1; e_wa = aj; e_wd = m_words[j];
            end
         end else begin
            v    = reg_val(aj);
            e_mo = v[7-b];
            if (b == 7) begin
               e_rd = 1; e_ra = inc ? 7'(aj + 7'd1) : aj;
            end
         end
      end
   endfunction

   task automatic cmp(input string tag, input bit inc, input logic we, input logic [6:0] wa,
                      input logic [7:0] wd, input logic re, input logic [6:0] ra, input logic mo);
      bit e_wr, e_rd, e_mo;
      logic [6:0] e_wa, e_ra;
      logic [7:0] e_wd;
      model(cur_k, inc, e_wr, e_wa, e_wd, e_rd, e_ra, e_mo);
      chk($sformatf("%s wr_en bit%0d", tag, cur_k), 32'(we), 32'(e_wr));
      if (e_wr) begin
         chk($sformatf("%s wr_addr bit%0d", tag, cur_k), 32'(wa), 32'(e_wa));
         chk($sformatf("%s wr_data bit%0d", tag, cur_k), 32'(wd), 32'(e_wd));
      end
      chk($sformatf("%s rd_en bit%0d", tag, cur_k), 32'(re), 32'(e_rd));
      if (e_rd) chk($sformatf("%s rd_addr bit%0d", tag, cur_k), 32'(ra), 32'(e_ra));
      chk($sformatf("%s miso bit%0d", tag, cur_k), 32'(mo), 32'(e_mo));
   endtask

   // Single compare process, mid-way through the low half of sclk.
   always @(negedge sclk) begin
      #2;
      if (valid) begin
         idle_cnt = 0;
         cmp("inc", 1'b1, wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i, miso_i);
         cmp("fix", 1'b0, wr_en_n, wr_addr_n, wr_data_n, rd_en_n, rd_addr_n, miso_n);
         if (wr_en_i) wlog_i.push_back({1'b0, wr_addr_i, wr_data_i});
         if (wr_en_n) wlog_n.push_back({1'b0, wr_addr_n, wr_data_n});
         if (rd_en_i) rlog_i.push_back(rd_addr_i);
         if (cur_k >= 8) mis_i = {mis_i[14:0], miso_i};
      end else begin
         idle_cnt++;
         chk("idle wr_en inc", 32'(wr_en_i), 0);
         chk("idle rd_en inc", 32'(rd_en_i), 0);
         chk("idle wr_en fix", 32'(wr_en_n), 0);
         chk("idle rd_en fix", 32'(rd_en_n), 0);
         if (idle_cnt >= 2) begin
            chk("idle miso inc", 32'(miso_i), 0);
            chk("idle miso fix", 32'(miso_n), 0);
         end
      end
   end

   task automatic all_zero(input string tag);
      chk({tag, " wr_en inc"},   32'(wr_en_i),   0);
      chk({tag, " wr_addr inc"}, 32'(wr_addr_i), 0);
      chk({tag, " wr_data inc"}, 32'(wr_data_i), 0);
      chk({tag, " rd_en inc"},   32'(rd_en_i),   0);
      chk({tag, " rd_addr inc"}, 32'(rd_addr_i), 0);
      chk({tag, " miso inc"},    32'(miso_i),    0);
      chk({tag, " wr_en fix"},   32'(wr_en_n),   0);
      chk({tag, " rd_en fix"},   32'(rd_en_n),   0);
      chk({tag, " miso fix"},    32'(miso_n),    0);
   endtask

   task automatic start_frame(input logic [7:0] hdr, input logic [7:0] w0,
                              input logic [7:0] w1, input logic [7:0] w2, input int nbits);
      logic [31:0] stream;
      stream = {hdr, w0, w1, w2};
      m_hdr = hdr; m_words[0] = w0; m_words[1] = w1; m_words[2] = w2;
      wlog_i.delete(); wlog_n.delete(); rlog_i.delete(); mis_i = '0;
      for (int k = 0; k < nbits; k++) begin
         @(negedge sclk);
         cs_n = 1'b0; mosi = stream[31-k]; cur_k = k; valid = 1'b1;
      end
   endtask

   task automatic end_frame();
      @(negedge sclk);
      valid = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      repeat (3) @(negedge sclk);
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [7:0] w0,
                             input logic [7:0] w1, input logic [7:0] w2, input int nbits);
      start_frame(hdr, w0, w1, w2, nbits);
      end_frame();
   endtask

   // Reset pulse after nbits bit periods of a frame, then deselect.
   task automatic reset_in_frame(input logic [7:0] hdr, input logic [7:0] w0, input int nbits);
      start_frame(hdr, w0, 8'h00, 8'h00, nbits);
      #3 rst_n = 1'b0;
      #1 all_zero($sformatf("rst@bit%0d", nbits - 1));
      @(negedge sclk);
      valid = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      #3 rst_n = 1'b1;
      repeat (3) @(negedge sclk);
   endtask

   function automatic logic [15:0] q16(input logic [15:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 16'hFFFF;
   endfunction

   initial begin
      rst_n = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      #1 all_zero("reset");
      #20 rst_n = 1'b1;
      repeat (2) @(negedge sclk);

      // Single write 0x05 <= 0xA5.
      send_frame(8'h85, 8'hA5, 8'h00, 8'h00, 16);
      chk("w1 count", wlog_i.size(), 1);
      chk("w1 entry", q16(wlog_i, 0), 16'h05A5);

      // Burst write with wrap at the top of the address space.
      send_frame(8'hFE, 8'h11, 8'h22, 8'h33, 32);
      chk("burst count", wlog_i.size(), 3);
      chk("burst w0", q16(wlog_i, 0), 16'h7E11);
      chk("burst w1", q16(wlog_i, 1), 16'h7F22);
      chk("burst w2 wrap", q16(wlog_i, 2), 16'h0033);
      chk("burst fix w2", q16(wlog_n, 2), 16'h7E33);

      // Burst read from 0x10.
      send_frame(8'h10, 8'h00, 8'h00, 8'h00, 24);
      chk("rd count", rlog_i.size(), 3);
      chk("rd addr0", 32'(rlog_i.size() > 0 ? rlog_i[0] : 7'h7F), 32'h10);
      chk("rd addr1", 32'(rlog_i.size() > 1 ? rlog_i[1] : 7'h7F), 32'h11);
      chk("rd addr2", 32'(rlog_i.size() > 2 ? rlog_i[2] : 7'h7F), 32'h12);
      chk("rd miso bytes", 32'(mis_i), 32'h5051);

      // Partial second word is dropped; next header still decodes.
      send_frame(8'h85, 8'h3C, 8'hC3, 8'h00, 21);
      chk("partial count", wlog_i.size(), 1);
      chk("partial entry", q16(wlog_i, 0), 16'h053C);
      send_frame(8'h8A, 8'h77, 8'h00, 8'h00, 16);
      chk("after partial count", wlog_i.size(), 1);
      chk("after partial entry", q16(wlog_i, 0), 16'h0A77);

      // Header too short is discarded entirely.
      send_frame(8'h85, 8'h00, 8'h00, 8'h00, 7);
      chk("short hdr writes", wlog_i.size(), 0);

      // Reset mid-header and mid-read (miso high at that moment).
      reset_in_frame(8'h90, 8'h00, 5);
      reset_in_frame(8'h10, 8'h00, 10);
      send_frame(8'h81, 8'h96, 8'h00, 8'h00, 16);
      chk("post-reset count", wlog_i.size(), 1);
      chk("post-reset entry", q16(wlog_i, 0), 16'h0196);

      // Fixed-address burst.
      send_frame(8'h83, 8'h01, 8'h02, 8'h03, 32);
      chk("fix count", wlog_n.size(), 3);
      chk("fix w0", q16(wlog_n, 0), 16'h0301);
      chk("fix w1", q16(wlog_n, 1), 16'h0302);
      chk("fix w2", q16(wlog_n, 2), 16'h0303);
      chk("inc w2", q16(wlog_i, 2), 16'h0503);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
